// File: rtl/mul_bt32s.sv
// ---------------------------------------------------------------------------
// mul_bt32s -- signed 32x32 -> 64-bit multiplier
//
// Radix-4 modified-Booth recoding produces 16 sign-extended partial products.
// Negative partial products are formed by inversion. The matching +1 for each
// one goes into a 17th "injection" row. The 17 rows are reduced by 3:2 CSA
// layers (17 -> 12 -> 8 -> 6 -> 4 -> 3 -> 2), and one 64-bit adder then
// produces the product. The result is registered. The unit accepts one
// operation per cycle and has no stall.
//
// Ports:
//   clk      in   1   clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   in_vld   in   1   op1/op2 valid this cycle
//   op1      in   32  multiplicand, two's-complement signed
//   op2      in   32  multiplier, two's-complement signed
//   out_vld  out  1   res holds a new product
//   res      out  64  signed product op1*op2
//
// Configuration macro: MUL_PIPE_EN
//   defined   : the CSA sum/carry rows are registered before the final adder
//               (latency 2)
//   undefined : only the output is registered (latency 1)
// ---------------------------------------------------------------------------
module mul_bt32s (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        out_vld,
    output logic [63:0] res
);

    // One 3:2 compressor across 64 bits.
    // Returns {carry << 1, sum}. The carry out of bit 63 is discarded.
    function automatic logic [127:0] csa(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input logic [63:0] c);
        logic [63:0] s;
        logic [63:0] cy;
        s  = a ^ b ^ c;
        cy = ((a & b) | (a & c) | (b & c)) << 1;
        return {cy, s};
    endfunction

    // Multiplier with the implicit op2[-1] = 0 appended below bit 0.
    logic [32:0] op2_ext;
    logic [63:0] m_ext;
    logic [63:0] inj;
    logic [63:0] pp [17];

    assign op2_ext = {op2, 1'b0};
    assign m_ext   = {{32{op1[31]}}, op1};

    genvar i;
    for (i = 0; i < 16; i++) begin : g_booth
        logic [2:0]  trip;
        logic [63:0] mag;
        logic        neg;

        assign trip = op2_ext[2*i+2 -: 3];

        // Booth digit magnitude: 0, M or 2M.
        always_comb begin
            mag = '0;
            case (trip)
                3'b001, 3'b010, 3'b101, 3'b110: mag = m_ext;
                3'b011, 3'b100:                 mag = m_ext << 1;
                default:                        mag = '0;
            endcase
        end

        // Digits -1 and -2 are negative. The 111 code is -0, so it is treated
        // as zero.
        assign neg   = trip[2] & ~(trip[1] & trip[0]);
        assign pp[i] = (neg ? ~mag : mag) << (2 * i);

        // The +1 that completes the negation lands at this row's weight, 2i.
        assign inj[2*i +: 2] = {1'b0, neg};
    end

    assign inj[63:32] = '0;
    assign pp[16]     = inj;

    // Carry-save reduction tree.
    logic [63:0] l1 [12];
    logic [63:0] l2 [8];
    logic [63:0] l3 [6];
    logic [63:0] l4 [4];
    logic [63:0] l5 [3];
    logic [63:0] sum_row;
    logic [63:0] carry_row;

    genvar g;
    for (g = 0; g < 5; g++) begin : g_l1
        assign {l1[2*g+1], l1[2*g]} = csa(pp[3*g], pp[3*g+1], pp[3*g+2]);
    end
    assign l1[10] = pp[15];
    assign l1[11] = pp[16];

    for (g = 0; g < 4; g++) begin : g_l2
        assign {l2[2*g+1], l2[2*g]} = csa(l1[3*g], l1[3*g+1], l1[3*g+2]);
    end

    for (g = 0; g < 2; g++) begin : g_l3
        assign {l3[2*g+1], l3[2*g]} = csa(l2[3*g], l2[3*g+1], l2[3*g+2]);
    end
    assign l3[4] = l2[6];
    assign l3[5] = l2[7];

    for (g = 0; g < 2; g++) begin : g_l4
        assign {l4[2*g+1], l4[2*g]} = csa(l3[3*g], l3[3*g+1], l3[3*g+2]);
    end

    assign {l5[1], l5[0]} = csa(l4[0], l4[1], l4[2]);
    assign l5[2]          = l4[3];

    assign {carry_row, sum_row} = csa(l5[0], l5[1], l5[2]);

`ifdef MUL_PIPE_EN
    logic [63:0] sum_q;
    logic [63:0] carry_q;
    logic        vld_q;

    // Intermediate stage that holds the two redundant rows ahead of the adder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            sum_q   <= sum_row;
            carry_q <= carry_row;
            vld_q   <= in_vld;
        end
    end

    // Final carry-propagate add, registered at the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res     <= '0;
            out_vld <= 1'b0;
        end else begin
            res     <= sum_q + carry_q;
            out_vld <= vld_q;
        end
    end
`else
    // Final carry-propagate add, registered at the output.
    // res updates every cycle whether or not in_vld is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res     <= '0;
            out_vld <= 1'b0;
        end else begin
            res     <= sum_row + carry_row;
            out_vld <= in_vld;
        end
    end
`endif

endmodule

// File: tb/tb_mul_bt32s.sv
// ---------------------------------------------------------------------------
// tb_mul_bt32s -- self-checking bench for mul_bt32s
//
// Directed corner products, a random back-to-back stream, and a reset pulled
// mid-stream. Expected results come from spec constants or from 64-bit signed
// integer multiplication. They are queued and compared after the configured
// latency (2 when MUL_PIPE_EN is defined, otherwise 1).
// ---------------------------------------------------------------------------
module tb_mul_bt32s;

`ifdef MUL_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        out_vld;
    logic [63:0] res;

    int tests;
    int failed;

    typedef struct {
        logic [63:0] prod;
        logic        vld;
        string       tag;
    } exp_t;

    exp_t pq[$];

    mul_bt32s dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .op1     (op1),
        .op2     (op2),
        .out_vld (out_vld),
        .res     (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact signed product in 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint x;
        x = longint'($signed(a)) * longint'($signed(b));
        return x;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] exp_res, input logic exp_vld);
        tests++;
        assert (res === exp_res) else begin
            failed++;
            $error("[TB] FAIL %s res: got %h want %h", tag, res, exp_res);
        end
        tests++;
        assert (out_vld === exp_vld) else begin
            failed++;
            $error("[TB] FAIL %s out_vld: got %b want %b", tag, out_vld, exp_vld);
        end
    endtask

    // Inputs are driven on the falling edge. Before driving, the oldest
    // queued expectation is checked once it has aged LAT cycles.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic v,
                                 input logic [63:0] exp_val, input bit use_exp, input string tag);
        exp_t e;
        @(negedge clk);
        if (pq.size() >= LAT) begin
            e = pq.pop_front();
            checkOutput(e.tag, e.prod, e.vld);
        end
        op1    = a;
        op2    = b;
        in_vld = v;
        e.prod = use_exp ? exp_val : model(a, b);
        e.vld  = v;
        e.tag  = tag;
        pq.push_back(e);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rv;
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        in_vld = 1'b0;
        op1    = '0;
        op2    = '0;

        // Reset state
        @(negedge clk);
        checkOutput("reset", 64'h0, 1'b0);
        @(negedge clk);
        checkOutput("reset_hold", 64'h0, 1'b0);
        rst_n = 1'b1;

        // Directed products with known answers
        applyStimulus(32'd15, 32'd14940, 1'b1, 64'h0000_0000_0003_6B64, 1'b1, "t1_pos");
        applyStimulus(32'd15, -32'd14940, 1'b1, 64'hFFFF_FFFF_FFFC_949C, 1'b1, "t2_neg");
        applyStimulus(32'h00B78034, 32'h00B33333, 1'b1, 64'h0000_8073_5774_E65C, 1'b1, "t3_mix");
        applyStimulus(32'h80000000, 32'h80000000, 1'b1, 64'h4000_0000_0000_0000, 1'b1, "min_min");
        applyStimulus(32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000_0000_8000_0000, 1'b1, "max_min");
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h1, 1'b1, "m1_m1");
        applyStimulus(32'h12345678, 32'h0, 1'b1, 64'h0, 1'b1, "x_zero");
        applyStimulus(32'h0, 32'hDEADBEEF, 1'b0, 64'h0, 1'b1, "zero_x_novld");
        applyStimulus(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFF_FFFF_0000_0001, 1'b1, "max_max");

        // Random back-to-back stream; res must follow even when in_vld=0
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom;
            rb = $urandom;
            rv = ($urandom_range(0, 3) != 0);
            applyStimulus(ra, rb, rv, 64'h0, 1'b0, "rand");
        end

        // Reset asserted between clock edges while the stream is in flight
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_async", 64'h0, 1'b0);
        pq.delete();
        in_vld = 1'b0;
        op1    = '0;
        op2    = '0;
        @(negedge clk);
        checkOutput("midrst_hold", 64'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'h00B78034, 32'h00B33333, 1'b1, 64'h0000_8073_5774_E65C, 1'b1, "post_rst_first");
        for (int k = 0; k < 20; k++) begin
            ra = $urandom;
            rb = $urandom;
            applyStimulus(ra, rb, 1'b1, 64'h0, 1'b0, "post_rst_rand");
        end

        // Drain the remaining expectations
        for (int k = 0; k < LAT; k++) begin
            applyStimulus(32'h0, 32'h0, 1'b0, 64'h0, 1'b0, "drain");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
